// File: rtl/counter_bench_pkg.sv
// Shared constants and width helpers for the multimode counter benchmark.
package counter_bench_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Largest count for a WIDTH-bit counter (WIDTH in 2..32).
  function automatic logic [31:0] max_count(input int width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

  // Bits needed to hold 0..prescale-1; never narrower than one bit.
  function automatic int pre_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: emits one tick every PRESCALE enabled cycles.
module counter_prescaler
  import counter_bench_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (PRESCALE == 1) begin : g_bypass
    // No state at all: every enabled cycle is a tick.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, clk, reset, clr};
    assign tick = en;
  end else begin : g_count
    localparam int PW = pre_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
      if (reset || clr) begin
        pre_cnt <= '0;
      end else if (en) begin
        pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + 1'b1;
      end
    end

    assign tick = en && (pre_cnt == LAST);
  end

endmodule

// File: rtl/counter_multimode_bench.sv
// Parametrised up/down counter with load, prescaler, wrap/saturate,
// terminal-count pulse and sticky overflow flag.
module counter_multimode_bench
  import counter_bench_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_count(WIDTH));

  logic             tick;
  logic             boundary;
  logic [WIDTH-1:0] q_step;

  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .tick  (tick)
  );

  // A load discards any coincident tick, so it also suppresses the event.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    boundary = 1'b0;
    q_step   = q;
    if (tick && !load) begin
      if (up) begin
        if (q == MAX_Q) begin
          boundary = 1'b1;
          q_step   = (SATURATE == CNT_SAT) ? q : '0;
        end else begin
          q_step = q + 1'b1;
        end
      end else begin
        if (q == '0) begin
          boundary = 1'b1;
          q_step   = (SATURATE == CNT_SAT) ? q : MAX_Q;
        end else begin
          q_step = q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      q  <= load ? load_val : q_step;
      tc <= boundary;
      // A boundary event wins over a coincident clear.
      if (boundary) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_multimode_bench.sv
// Directed bench: three counter configurations (wrap/P=1, wrap/P=4, sat/P=1).
module tb_counter_multimode_bench;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_en, a_up, a_load, a_clr, a_tc, a_ovf;
  logic [7:0] a_load_val, a_q;
  logic       b_en, b_up, b_load, b_clr, b_tc, b_ovf;
  logic [7:0] b_load_val, b_q;
  logic       c_en, c_up, c_load, c_clr, c_tc, c_ovf;
  logic [7:0] c_load_val, c_q;

  counter_multimode_bench #(.WIDTH(8), .PRESCALE(1), .SATURATE(0)) dut_a (
    .clk(clk), .reset(reset), .en(a_en), .up(a_up), .load(a_load),
    .load_val(a_load_val), .clr_ovf(a_clr), .q(a_q), .tc(a_tc), .ovf(a_ovf)
  );

  counter_multimode_bench #(.WIDTH(8), .PRESCALE(4), .SATURATE(0)) dut_b (
    .clk(clk), .reset(reset), .en(b_en), .up(b_up), .load(b_load),
    .load_val(b_load_val), .clr_ovf(b_clr), .q(b_q), .tc(b_tc), .ovf(b_ovf)
  );

  counter_multimode_bench #(.WIDTH(8), .PRESCALE(1), .SATURATE(1)) dut_c (
    .clk(clk), .reset(reset), .en(c_en), .up(c_up), .load(c_load),
    .load_val(c_load_val), .clr_ovf(c_clr), .q(c_q), .tc(c_tc), .ovf(c_ovf)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] q, input logic tc, input logic ovf);
    check({tag, ".q"}, 32'(a_q), 32'(q));
    check({tag, ".tc"}, 32'(a_tc), 32'(tc));
    check({tag, ".ovf"}, 32'(a_ovf), 32'(ovf));
  endtask

  task automatic chk_b(input string tag, input logic [7:0] q, input logic tc, input logic ovf);
    check({tag, ".q"}, 32'(b_q), 32'(q));
    check({tag, ".tc"}, 32'(b_tc), 32'(tc));
    check({tag, ".ovf"}, 32'(b_ovf), 32'(ovf));
  endtask

  task automatic chk_c(input string tag, input logic [7:0] q, input logic tc, input logic ovf);
    check({tag, ".q"}, 32'(c_q), 32'(q));
    check({tag, ".tc"}, 32'(c_tc), 32'(tc));
    check({tag, ".ovf"}, 32'(c_ovf), 32'(ovf));
  endtask

  initial begin
    a_en = 0; a_up = 1; a_load = 0; a_clr = 0; a_load_val = 8'h00;
    b_en = 0; b_up = 1; b_load = 0; b_clr = 0; b_load_val = 8'h00;
    c_en = 0; c_up = 1; c_load = 0; c_clr = 0; c_load_val = 8'h00;

    // Reset state of all three instances.
    step(); step();
    chk_a("rst_a", 8'h00, 1'b0, 1'b0);
    chk_b("rst_b", 8'h00, 1'b0, 1'b0);
    chk_c("rst_c", 8'h00, 1'b0, 1'b0);
    reset = 0;

    // A: full up-count wrap over 256 ticks.
    a_en = 1; a_up = 1;
    for (int i = 1; i <= 256; i++) begin
      step();
      check("a_up.q", 32'(a_q), 32'(i % 256));
      check("a_up.tc", 32'(a_tc), 32'(i == 256));
      if (i == 255) check("a_up.ovf_pre", 32'(a_ovf), 32'd0);
    end
    check("a_wrap.ovf", 32'(a_ovf), 32'd1);
    a_en = 0;
    step();
    chk_a("a_idle", 8'h00, 1'b0, 1'b1);

    // A: down from 0 wraps to FF; clr_ovf coincident with the event loses.
    a_en = 1; a_up = 0; a_clr = 1;
    step();
    chk_a("a_down_wrap", 8'hFF, 1'b1, 1'b1);
    a_en = 0;
    step();
    chk_a("a_clr_ovf", 8'hFF, 1'b0, 1'b0);
    a_clr = 0;

    // A: load beats a coincident tick.
    a_en = 1; a_up = 1; a_load = 1; a_load_val = 8'h55;
    step();
    chk_a("a_load", 8'h55, 1'b0, 1'b0);
    a_load = 0;
    step();
    chk_a("a_after_load", 8'h56, 1'b0, 1'b0);
    a_en = 0;

    // C: saturating up count at the top.
    c_load = 1; c_load_val = 8'hFE;
    step();
    chk_c("c_load", 8'hFE, 1'b0, 1'b0);
    c_load = 0; c_en = 1; c_up = 1;
    step();
    chk_c("c_sat1", 8'hFF, 1'b0, 1'b0);
    step();
    chk_c("c_sat2", 8'hFF, 1'b1, 1'b1);
    step();
    chk_c("c_sat3", 8'hFF, 1'b1, 1'b1);
    // C: load leaves ovf alone; saturating down count clamps at 0.
    c_load = 1; c_load_val = 8'h00;
    step();
    chk_c("c_load0", 8'h00, 1'b0, 1'b1);
    c_load = 0; c_up = 0; c_clr = 1;
    step();
    chk_c("c_sat_dn", 8'h00, 1'b1, 1'b1);
    c_en = 0;
    step();
    chk_c("c_clr", 8'h00, 1'b0, 1'b0);
    c_clr = 0;

    // B: prescale 4 with enable pattern 1,1,0,1,1.
    b_en = 1; b_up = 1;
    step(); chk_b("b_e1", 8'h00, 1'b0, 1'b0);
    step(); chk_b("b_e2", 8'h00, 1'b0, 1'b0);
    b_en = 0;
    step(); chk_b("b_hold", 8'h00, 1'b0, 1'b0);
    b_en = 1;
    step(); chk_b("b_e3", 8'h00, 1'b0, 1'b0);
    step(); chk_b("b_e4", 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); check("b_mid.q", 32'(b_q), 32'h01);
    end
    step(); chk_b("b_step2", 8'h02, 1'b0, 1'b0);

    // B: load coincident with a tick, then the prescaler restarts.
    for (int i = 0; i < 3; i++) step();
    check("b_pre_load.q", 32'(b_q), 32'h02);
    b_load = 1; b_load_val = 8'h55;
    step(); chk_b("b_load", 8'h55, 1'b0, 1'b0);
    b_load = 0;
    for (int i = 0; i < 3; i++) begin
      step(); check("b_restart.q", 32'(b_q), 32'h55);
    end
    step(); chk_b("b_restart_tick", 8'h56, 1'b0, 1'b0);

    // B: down-wrap to set ovf; tc lasts a single cycle.
    b_load = 1; b_load_val = 8'h00;
    step();
    b_load = 0; b_up = 0;
    for (int i = 0; i < 3; i++) step();
    check("b_dn_pre.q", 32'(b_q), 32'h00);
    step(); chk_b("b_dn_wrap", 8'hFF, 1'b1, 1'b1);
    step(); chk_b("b_tc_single", 8'hFF, 1'b0, 1'b1);
    b_load = 1; b_load_val = 8'h80;
    step(); chk_b("b_load80", 8'h80, 1'b0, 1'b1);

    // B: reset wins over load and enable.
    reset = 1; b_load_val = 8'h33;
    step(); chk_b("b_reset", 8'h00, 1'b0, 1'b0);
    reset = 0; b_load = 0; b_up = 1; b_en = 1;
    for (int i = 0; i < 3; i++) begin
      step(); check("b_resume.q", 32'(b_q), 32'h00);
    end
    step(); chk_b("b_resume_tick", 8'h01, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_multimode_bench.md
# counter_multimode_bench

Parametrised successor to the fixed 8-bit counter benchmark, mapped onto the FPGA fabric and exercised through the same formal-verification wrapper flow. It adds:

- configurable width
- up/down direction
- parallel load
- a clock-enable prescaler
- wrap or saturate mode
- a terminal-count pulse and a sticky overflow flag

It is a user-design benchmark. It runs on the fabric global `clk`/`reset` nets, and all of its I/O maps to SOC pads.

## Interface
Parameters:
- `WIDTH`, 8: counter width; legal range 2..32.
- `PRESCALE`, 1: enabled cycles per count step; legal range 1..256.
- `SATURATE`, 0: 0 = wrap at the bound, 1 = clamp at the bound.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock, and reset is synchronous active-high.
- `en`  in  1  count enable; advances the prescaler.
- `up`  in  1  direction; 1 = increment, 0 = decrement.
- `load`  in  1  parallel load strobe.
- `load_val`  in  `WIDTH`  value loaded when `load` = 1.
- `clr_ovf`  in  1  clears the sticky overflow flag.
- `q`  out  `WIDTH`  registered count.
- `tc`  out  1  registered one-cycle terminal-count pulse.
- `ovf`  out  1  registered sticky boundary flag.

## Operation
- Priority at each rising edge: `reset` > `load` > step > hold.
- Reset values: `q` = 0, `tc` = 0, `ovf` = 0, internal `pre_cnt` = 0.
- Prescaler `pre_cnt` (range 0..`PRESCALE`-1):
  - With `en` = 1, `pre_cnt` increments each cycle.
  - `tick` = `en` && (`pre_cnt` == `PRESCALE`-1); on `tick`, `pre_cnt` returns to 0.
  - With `en` = 0, `pre_cnt` holds.
  - `PRESCALE` = 1 makes `tick` = `en`.
- Load: `q` <= `load_val` and `pre_cnt` <= 0; `tc` <= 0. Any coincident tick is discarded.
- Step on `tick`, up direction:
  - If `q` == 2^`WIDTH`-1, a boundary event occurs: `q` <= 0 when `SATURATE` = 0, or `q` holds when `SATURATE` = 1.
  - Otherwise `q` <= `q`+1.
- Step on `tick`, down direction:
  - If `q` == 0, a boundary event occurs: `q` <= 2^`WIDTH`-1 when `SATURATE` = 0, or `q` holds at 0 when `SATURATE` = 1.
  - Otherwise `q` <= `q`-1.
- Every tick at the bound is a boundary event. This includes repeated ticks while clamped in saturate mode.
- `tc` <= 1 only on an edge that performs a boundary event; otherwise `tc` <= 0.
- `ovf`:
  - Set by a boundary event.
  - Cleared by `clr_ovf` when no boundary event occurs in the same cycle; if both happen together, set wins.
  - `load` does not affect `ovf`.
- Arithmetic is unsigned modulo 2^`WIDTH`; no intermediate value is wider than `WIDTH`+1.
- Direction change (`up` toggling) takes effect on the next tick and leaves `pre_cnt` unaffected.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Latency from `load` to `q` is 1 cycle.
- Latency from `tick` to `q`/`tc`/`ovf` is 1 cycle.
- With `en` held high from the first cycle after reset release, the first `q` change appears after edge `PRESCALE`; subsequent changes follow every `PRESCALE` edges.
- `tc` is never high for two consecutive cycles when `PRESCALE` > 1. With `PRESCALE` = 1 and saturate mode held at the bound, `tc` stays high continuously.
- Reset asserted mid-count clears all state at the next edge, regardless of `load` or `en`.

## Structure
- Shared package `counter_bench_pkg` holds:
  - mode constants `CNT_WRAP` = 0 and `CNT_SAT` = 1
  - a function returning the maximum count for a given `WIDTH`
  - `$clog2`-based width helpers for the prescaler
- One sub-module, `counter_prescaler`:
  - inputs: `clk`, `reset`, `en`, `clr` (driven by `load`)
  - output: `tick`
  - parameter: `PRESCALE`
  - It is instantiated once; at `PRESCALE` = 1 it degenerates to a wire with no state.
- Top level holds the `q`/`tc`/`ovf` registers and the next-state logic.

## Test plan
- Reset then `en` = 1, `up` = 1, `WIDTH` = 8, `PRESCALE` = 1: `q` goes 0,1,2,…; after 256 ticks `q` = 0, with `tc` = 1 for one cycle and `ovf` = 1.
- `PRESCALE` = 4, `en` toggling as 1,1,0,1,1: `q` increments exactly once, after the 4th enabled cycle; `pre_cnt` freezes while `en` = 0.
- `SATURATE` = 1, `load_val` = 0xFE, `load`, then 3 up ticks: `q` = 0xFF, 0xFF, 0xFF; `tc` stays 0 on the first tick and is 1 on the next two; `ovf` = 1.
- `up` = 0 from `q` = 0 in wrap mode: `q` = 0xFF, `tc` pulses; then `clr_ovf` on a cycle with no event gives `ovf` = 0. `clr_ovf` coincident with a boundary event leaves `ovf` = 1.
- `load` = 1 with `load_val` = 0x55 coincident with a tick: `q` = 0x55 (no increment), `tc` = 0, prescaler restarts.
- `reset` asserted while `q` = 0x80, `ovf` = 1, and `load` active: next cycle `q` = 0, `tc` = 0, `ovf` = 0; counting resumes from 0 after `PRESCALE` enabled cycles.
